// File: rtl/zero_skip_mac_array_if.sv
// Stream bundle for zero_skip_mac_array.
//   Input side : in_valid/in_ready handshake carrying first/last tags,
//                a per-lane mask, packed weights/activations and the
//                requantisation config (cfg_shift, cfg_relu).
//   Output side: out_valid/out_ready handshake carrying the requantised
//                result (out_data), the raw accumulator (out_acc), the
//                performed-MAC count (out_ops) and the saturation flag.
// master = producer/consumer around the block, slave = the MAC array.
interface zero_skip_mac_array_if #(
  parameter int LANES       = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int ACC_WIDTH   = 32,
  parameter int OUT_WIDTH   = 8,
  parameter int SHIFT_WIDTH = 5,
  parameter int CNT_WIDTH   = 16
);
  logic                        in_valid;
  logic                        in_ready;
  logic                        in_first;
  logic                        in_last;
  logic [LANES-1:0]            in_mask;
  logic [LANES*DATA_WIDTH-1:0] in_weight;
  logic [LANES*DATA_WIDTH-1:0] in_act;
  logic [SHIFT_WIDTH-1:0]      cfg_shift;
  logic                        cfg_relu;
  logic                        out_valid;
  logic                        out_ready;
  logic [OUT_WIDTH-1:0]        out_data;
  logic [ACC_WIDTH-1:0]        out_acc;
  logic [CNT_WIDTH-1:0]        out_ops;
  logic                        out_sat;

  modport master (
    output in_valid, in_first, in_last, in_mask, in_weight, in_act,
           cfg_shift, cfg_relu, out_ready,
    input  in_ready, out_valid, out_data, out_acc, out_ops, out_sat
  );

  modport slave (
    input  in_valid, in_first, in_last, in_mask, in_weight, in_act,
           cfg_shift, cfg_relu, out_ready,
    output in_ready, out_valid, out_data, out_acc, out_ops, out_sat
  );
endinterface

// File: rtl/zero_skip_mac_array.sv
// Multi-lane zero-skip MAC with requantised, back-pressured output.
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : zero_skip_mac_array_if.slave (input beats in, results out)
// Pipeline: stage P registers the masked lane sum and beat tags, stage A
// accumulates into acc/ops and, on a last beat, loads the held output
// register with the requantised result. The whole pipe stalls while a
// result is held and not taken.
module zero_skip_mac_array #(
  parameter int LANES       = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int ACC_WIDTH   = 32,
  parameter int OUT_WIDTH   = 8,
  parameter int SHIFT_WIDTH = 5,
  parameter int CNT_WIDTH   = 16
) (
  input logic                 clk,
  input logic                 rst,
  zero_skip_mac_array_if.slave bus
);

  localparam int POP_WIDTH = $clog2(LANES + 1);
  // Output clamp bounds at the widened requant width; min is ~max in two's complement.
  localparam logic signed [ACC_WIDTH:0] OUT_MAX =
    signed'((ACC_WIDTH+1)'((64'd1 << (OUT_WIDTH - 1)) - 64'd1));
  localparam logic signed [ACC_WIDTH:0] OUT_MIN = ~OUT_MAX;

  logic advance;
  assign advance     = !(bus.out_valid && !bus.out_ready);
  assign bus.in_ready = advance && !rst;

  // ---------------- Stage P: masked lane products ----------------
  logic signed [2*DATA_WIDTH-1:0] prod [LANES];
  logic signed [ACC_WIDTH-1:0]    lane_sum_d;
  logic [POP_WIDTH-1:0]           pop_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    lane_sum_d = '0;
    pop_d      = '0;
    for (int i = 0; i < LANES; i++) begin
      prod[i] = signed'(bus.in_weight[i*DATA_WIDTH +: DATA_WIDTH]) *
                signed'(bus.in_act[i*DATA_WIDTH +: DATA_WIDTH]);
      if (bus.in_mask[i]) begin
        lane_sum_d = lane_sum_d + ACC_WIDTH'(prod[i]);
        pop_d      = pop_d + POP_WIDTH'(1);
      end
    end
  end

  logic                        p_valid_q;
  logic signed [ACC_WIDTH-1:0] p_sum_q;
  logic [POP_WIDTH-1:0]        p_pop_q;
  logic                        p_first_q, p_last_q, p_relu_q;
  logic [SHIFT_WIDTH-1:0]      p_shift_q;

  always_ff @(posedge clk) begin
    // NOTE: sequential state is always assigned with <= so all registers update from pre-edge values.
    if (rst)          p_valid_q <= 1'b0;
    else if (advance) p_valid_q <= bus.in_valid;
  end

  // NOTE: payload registers carry no reset; they are only consumed when p_valid_q is set.
  always_ff @(posedge clk) begin
    if (advance) begin
      p_sum_q   <= lane_sum_d;
      p_pop_q   <= pop_d;
      p_first_q <= bus.in_first;
      p_last_q  <= bus.in_last;
      p_shift_q <= bus.cfg_shift;
      p_relu_q  <= bus.cfg_relu;
    end
  end

  // ---------------- Stage A: accumulate and requantise ----------------
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0]        ops_q, ops_d;
  logic [CNT_WIDTH:0]          ops_sum;
  logic signed [ACC_WIDTH:0]   rq_wide, rq_round, rq_val;
  logic [OUT_WIDTH-1:0]        data_d;
  logic                        sat_d;

  always_comb begin
    acc_d   = (p_first_q ? '0 : acc_q) + p_sum_q;
    ops_sum = {1'b0, (p_first_q ? '0 : ops_q)} + (CNT_WIDTH+1)'(p_pop_q);
    ops_d   = ops_sum[CNT_WIDTH] ? '1 : ops_sum[CNT_WIDTH-1:0];

    // Round-half-up shift at one extra bit so the rounding add cannot overflow.
    rq_wide  = {acc_d[ACC_WIDTH-1], acc_d};
    rq_round = signed'((ACC_WIDTH+1)'(1) << (p_shift_q - SHIFT_WIDTH'(1)));
    rq_val   = rq_wide;
    if (p_shift_q != '0) rq_val = (rq_wide + rq_round) >>> p_shift_q;
    if (p_relu_q && rq_val[ACC_WIDTH]) rq_val = '0;

    sat_d  = 1'b0;
    data_d = rq_val[OUT_WIDTH-1:0];
    if (rq_val > OUT_MAX) begin
      data_d = OUT_MAX[OUT_WIDTH-1:0];
      sat_d  = 1'b1;
    end else if (rq_val < OUT_MIN) begin
      data_d = OUT_MIN[OUT_WIDTH-1:0];
      sat_d  = 1'b1;
    end
  end

  logic                 out_valid_q, out_sat_q;
  logic [OUT_WIDTH-1:0] out_data_q;
  logic [ACC_WIDTH-1:0] out_acc_q;
  logic [CNT_WIDTH-1:0] out_ops_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      ops_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_acc_q   <= '0;
      out_ops_q   <= '0;
      out_sat_q   <= 1'b0;
    end else if (advance) begin
      if (p_valid_q) begin
        acc_q <= acc_d;
        ops_q <= ops_d;
      end
      // advance implies the held result (if any) is being taken this cycle,
      // so valid simply follows whether a new result loads.
      out_valid_q <= p_valid_q && p_last_q;
      if (p_valid_q && p_last_q) begin
        out_data_q <= data_d;
        out_acc_q  <= acc_d;
        out_ops_q  <= ops_d;
        out_sat_q  <= sat_d;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_acc   = out_acc_q;
  assign bus.out_ops   = out_ops_q;
  assign bus.out_sat   = out_sat_q;

endmodule

// File: tb/tb_zero_skip_mac_array.sv
// Self-checking bench for zero_skip_mac_array: directed test-plan cases,
// an ops-saturation run, reset mid-product, backpressure and a randomized
// phase checked against a dot-product/requant reference model.
module tb_zero_skip_mac_array;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  zero_skip_mac_array_if bus ();

  zero_skip_mac_array dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] acc;
    logic [7:0]  data;
    logic [15:0] ops;
    logic        sat;
  } exp_t;

  exp_t exp_q[$];
  int   acc_m = 0;
  int   ops_m = 0;
  bit   stop_rand = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] pack4(input int l0, input int l1, input int l2, input int l3);
    logic [7:0] b0, b1, b2, b3;
    b0 = 8'(l0); b1 = 8'(l1); b2 = 8'(l2); b3 = 8'(l3);
    return {b3, b2, b1, b0};
  endfunction

  // Reference requantisation: round-half-up shift, ReLU, clamp to int8.
  function automatic exp_t make_exp(input int acc, input int ops, input int sh, input bit relu);
    exp_t   e;
    longint r;
    r = acc;
    if (sh > 0) r = (r + (longint'(1) << (sh - 1))) >>> sh;
    if (relu && r < 0) r = 0;
    e.sat = 1'b0;
    if (r > 127) begin r = 127; e.sat = 1'b1; end
    else if (r < -128) begin r = -128; e.sat = 1'b1; end
    e.acc  = 32'(acc);
    e.data = 8'(r);
    e.ops  = 16'(ops);
    return e;
  endfunction

  // Drive one beat (caller is just after a posedge) and wait for acceptance.
  task automatic send(input bit first, input bit last, input logic [3:0] mask,
                      input logic [31:0] w, input logic [31:0] a,
                      input int sh, input bit relu);
    int n = 0;
    bus.in_valid  = 1'b1;
    bus.in_first  = first;
    bus.in_last   = last;
    bus.in_mask   = mask;
    bus.in_weight = w;
    bus.in_act    = a;
    bus.cfg_shift = 5'(sh);
    bus.cfg_relu  = relu;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("accept_wait", bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    if (first) begin acc_m = 0; ops_m = 0; end
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) begin
        acc_m += int'($signed(w[i*8 +: 8])) * int'($signed(a[i*8 +: 8]));
        ops_m = (ops_m + 1 > 65535) ? 65535 : ops_m + 1;
      end
    end
    if (last) exp_q.push_back(make_exp(acc_m, ops_m, sh, relu));
  endtask

  // Wait for the next valid result and compare against literal expectations.
  task automatic expect_out(input string tag, input logic [31:0] acc, input logic [7:0] data,
                            input logic [15:0] ops, input logic sat);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.out_valid && n < 20);
    check({tag, "_valid"}, bus.out_valid, 1);
    check({tag, "_acc"},   bus.out_acc,   acc);
    check({tag, "_data"},  bus.out_data,  data);
    check({tag, "_ops"},   bus.out_ops,   ops);
    check({tag, "_sat"},   bus.out_sat,   sat);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  // Scoreboard monitor: every completed output handshake must match the model,
  // and a held result must stay stable until taken.
  bit   held = 1'b0;
  exp_t held_v;
  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check("hold_stable_acc",  bus.out_acc,  held_v.acc);
        check("hold_stable_data", bus.out_data, held_v.data);
        check("hold_valid",       bus.out_valid, 1);
      end
      held = 1'b0;
      if (bus.out_valid) begin
        if (bus.out_ready) begin
          if (exp_q.size() == 0) begin
            check("spurious_out", bus.out_valid, 0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("sb_acc",  bus.out_acc,  e.acc);
            check("sb_data", bus.out_data, e.data);
            check("sb_ops",  bus.out_ops,  e.ops);
            check("sb_sat",  bus.out_sat,  e.sat);
          end
        end else begin
          held        = 1'b1;
          held_v.acc  = bus.out_acc;
          held_v.data = bus.out_data;
        end
      end
    end
  end

  initial begin
    logic [31:0] w1234, a10;
    w1234 = pack4(1, 2, 3, 4);
    a10   = pack4(10, 10, 10, 10);
    bus.in_valid = 1'b0; bus.in_first = 1'b0; bus.in_last = 1'b0;
    bus.in_mask = '0; bus.in_weight = '0; bus.in_act = '0;
    bus.cfg_shift = '0; bus.cfg_relu = 1'b0; bus.out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_acc",   bus.out_acc,   0);
    check("rst_in_ready_rel", bus.in_ready, 1);

    // One-beat product with latency check
    @(posedge clk); #1;
    send(1, 1, 4'b1111, w1234, a10, 0, 0);
    @(negedge clk);
    check("lat_t1_valid", bus.out_valid, 0);
    expect_out("onebeat", 32'd100, 8'd100, 16'd4, 1'b0);

    // Mask skip: lanes 0 and 2 only
    @(posedge clk); #1;
    send(1, 1, 4'b0101, pack4(5, 5, 5, 5), pack4(2, 2, 2, 2), 0, 0);
    expect_out("mask", 32'd20, 8'd20, 16'd2, 1'b0);

    // Three beats, shift 2
    @(posedge clk); #1;
    send(1, 0, 4'b1111, w1234, a10, 0, 0);
    send(0, 0, 4'b1111, w1234, a10, 0, 0);
    send(0, 1, 4'b1111, w1234, a10, 2, 0);
    expect_out("three", 32'd300, 8'd75, 16'd12, 1'b0);
    @(posedge clk); #1;
    send(1, 0, 4'b1111, w1234, a10, 0, 0);
    send(0, 0, 4'b1111, w1234, a10, 0, 0);
    send(0, 1, 4'b1111, w1234, pack4(12, 10, 10, 10), 2, 0);
    expect_out("round", 32'd302, 8'd76, 16'd12, 1'b0);

    // Saturation and ReLU
    @(posedge clk); #1;
    send(1, 1, 4'b0011, pack4(100, 100, 0, 0), pack4(5, 5, 0, 0), 0, 0);
    expect_out("sat_pos", 32'd1000, 8'd127, 16'd2, 1'b1);
    @(posedge clk); #1;
    send(1, 1, 4'b0011, pack4(100, 100, 0, 0), pack4(-5, -5, 0, 0), 0, 0);
    expect_out("sat_neg", 32'hFFFF_FC18, 8'h80, 16'd2, 1'b1);
    @(posedge clk); #1;
    send(1, 1, 4'b0011, pack4(100, 100, 0, 0), pack4(-5, -5, 0, 0), 0, 1);
    expect_out("relu", 32'hFFFF_FC18, 8'd0, 16'd2, 1'b0);

    // All-masked beat still completes a product
    @(posedge clk); #1;
    send(1, 1, 4'b0000, w1234, a10, 0, 0);
    expect_out("mask0", 32'd0, 8'd0, 16'd0, 1'b0);

    // Backpressure: four back-to-back one-beat products
    @(posedge clk); #1;
    fork
      begin
        for (int k = 0; k < 4; k++)
          send(1, 1, 4'b1111, pack4(k + 1, 1, 1, 1), pack4(3, k, 2, 1), 0, 0);
      end
      begin
        int n = 0;
        do begin
          @(posedge clk); #1;
          n++;
        end while (!bus.out_valid && n < 20);
        bus.out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          check("bp_in_ready_low", bus.in_ready, 0);
          @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Reset mid-product
    @(posedge clk); #1;
    send(1, 0, 4'b1111, w1234, a10, 0, 0);
    send(0, 0, 4'b1111, w1234, a10, 0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    acc_m = 0; ops_m = 0;
    @(negedge clk);
    check("rst2_valid", bus.out_valid, 0);
    check("rst2_data",  bus.out_data,  0);
    check("rst2_acc",   bus.out_acc,   0);
    check("rst2_ops",   bus.out_ops,   0);
    check("rst2_sat",   bus.out_sat,   0);
    @(posedge clk); #1;
    send(1, 1, 4'b1011, pack4(1, 2, 9, 4), pack4(1, 3, 5, 0), 0, 0);
    expect_out("post_rst", 32'd7, 8'd7, 16'd3, 1'b0);

    // Ops counter saturation at all-ones
    @(posedge clk); #1;
    for (int k = 0; k < 16400; k++)
      send(k == 0, k == 16399, 4'b1111, '0, '0, 0, 0);
    expect_out("ops_sat", 32'd0, 8'd0, 16'hFFFF, 1'b0);

    // Randomized products with random backpressure
    @(posedge clk); #1;
    fork
      begin
        while (!stop_rand) begin
          @(posedge clk); #1;
          if (!stop_rand) bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
      begin
        for (int p = 0; p < 60; p++) begin
          int beats;
          beats = $urandom_range(1, 4);
          for (int b = 0; b < beats; b++)
            send(b == 0, b == beats - 1, 4'($urandom_range(0, 15)),
                 $urandom, $urandom, $urandom_range(0, 14), 1'($urandom_range(0, 1)));
        end
        stop_rand = 1'b1;
      end
    join
    bus.out_ready = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/zero_skip_mac_array.md
# zero_skip_mac_array

Multi-lane successor to the single-lane zero-skip MAC. Each accepted beat carries LANES weight/activation pairs plus a per-lane mask from the sparse weight reader; masked lanes issue no multiply and contribute zero. Per-lane products are summed and accumulated across beats delimited by first/last tags. The finished dot product is requantised (rounding shift, optional ReLU, saturation) into a held output register with valid/ready backpressure. The block sits between the compressed weight reader and the output activation writer.

## Interface
- LANES, 4, parallel weight/activation pairs per beat
- DATA_WIDTH, 8, signed weight and activation width
- ACC_WIDTH, 32, accumulator width, two's complement
- OUT_WIDTH, 8, signed requantised output width
- SHIFT_WIDTH, 5, width of cfg_shift
- CNT_WIDTH, 16, width of performed-MAC counter
- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid && in_ready
- in_first  in  1  first beat of a dot product; restarts accumulation
- in_last  in  1  final beat of a dot product
- in_mask  in  LANES  lane enable; 0 = zero weight, lane skipped
- in_weight  in  LANES*DATA_WIDTH  lane i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- in_act  in  LANES*DATA_WIDTH  same packing as in_weight
- cfg_shift  in  SHIFT_WIDTH  requant right-shift amount, sampled with the last beat
- cfg_relu  in  1  clamp negatives to 0, sampled with the last beat
- out_valid  out  1  result held valid
- out_ready  in  1  consumer accepts result
- out_data  out  OUT_WIDTH  requantised result
- out_acc  out  ACC_WIDTH  raw accumulator value of the result
- out_ops  out  CNT_WIDTH  count of unmasked lane MACs in the dot product, saturating at all-ones
- out_sat  out  1  1 when out_data was clamped by saturation (not by ReLU)

## Operation
- Stage P, on accept: per lane, product = mask ? w*a : 0, sign-extended to ACC_WIDTH. The lane sum wraps modulo 2^ACC_WIDTH. Popcount(in_mask) is registered with the first, last, shift and relu tags.
- Stage A: acc_next = (first ? 0 : acc) + lane_sum. ops_next = (first ? 0 : ops) + popcount, saturating. acc and ops are updated.
- If last: out_acc <= acc_next and out_ops <= ops_next. out_data <= requant(acc_next). out_valid <= 1.
- requant:
  - If shift > 0, r = (acc + (1 << (shift-1))) >>> shift, computed at ACC_WIDTH+1 bits; else r = acc.
  - If relu and r < 0, r = 0.
  - Clamp to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]; out_sat = clamped.
- Stall: advance = !(out_valid && !out_ready). in_ready = advance && !rst. When advance = 0, stages P and A and the acc/ops registers hold.
- out_valid clears on out_ready unless a new last loads the register in the same cycle. In that case the new result replaces the old with no gap.
- A beat with first && last is a complete one-beat dot product.
- A beat with in_mask = 0 is still valid. It propagates its first/last tags and adds 0.
- A beat without first, following a completed dot product, accumulates onto the previous acc. This is legal and is the caller's responsibility.
- Reset clears:
  - acc, ops and the stage valids to 0;
  - out_valid, out_data, out_acc, out_ops and out_sat to 0.
- A dot product in flight at reset is discarded.

## Timing
- Throughput: 1 beat/cycle while out_ready = 1 or out_valid = 0.
- Latency: last beat accepted at cycle t → out_valid = 1 at cycle t+2.
- Back-to-back single-beat dot products produce out_valid on consecutive cycles when out_ready = 1.
- out_* are stable while out_valid && !out_ready.
- in_ready falls combinationally in the cycle out_valid && !out_ready. At most one result is ever held; none is dropped.
- cfg_shift and cfg_relu are ignored on non-last beats.

## Test plan
All cases use LANES=4, DATA_WIDTH=8, OUT_WIDTH=8.
- One-beat first+last: w={1,2,3,4}, a={10,10,10,10}, mask=1111, shift=0 → at t+2: out_acc=100, out_data=100, out_ops=4, out_sat=0.
- Mask skip: w={5,5,5,5}, a={2,2,2,2}, mask=0101 → out_acc=20, out_ops=2.
- Three beats, each lane sum 100, shift=2 → out_acc=300, out_data=75, out_ops=12. Same with a lane sum of 102 on the last beat, giving acc=302 → out_data=76 (round half up).
- Saturation:
  - acc=1000, shift=0 → out_data=127, out_sat=1.
  - acc=-1000 → out_data=-128, out_sat=1.
  - acc=-1000 with cfg_relu=1 → out_data=0, out_sat=0.
- Backpressure: four back-to-back one-beat products with out_ready low for 5 cycles after the first out_valid → in_ready low while held; all four results delivered in order with correct values and no duplicates.
- Reset mid-product: 2 non-last beats, then rst for 1 cycle, then first+last with sum 7 → out_acc=7, out_ops=popcount of that beat. All outputs read 0 and out_valid=0 in the cycle after rst.
